// File: rtl/matrix_stream_io.sv
// Serial load of two 3x3 16-bit operand matrices, one-cycle capture of the
// external multiplier's product, then serial streaming of the nine results.
module matrix_stream_io (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [143:0] matrix_A,
    output logic [143:0] matrix_B,
    input  logic [143:0] Result,
    output logic [15:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_CAPTURE,
        ST_SEND
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic [143:0]   mat_a_q, mat_a_d;
    logic [143:0]   mat_b_q, mat_b_d;
    logic [143:0]   res_q, res_d;
    logic           accept;
    logic           emit;
    logic [15:0]    res_elem;

    assign accept = (state_q == ST_LOAD) && in_valid;
    assign emit   = (state_q == ST_SEND) && out_ready;

    always_comb begin
        res_elem = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            if (idx_q == 4'(i)) begin
                res_elem = res_q[143-16*i -: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        res_d   = res_q;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    // Slots 0-8 land in A, 9-17 in B, both row-major.
                    for (int i = 0; i < 9; i++) begin
                        if (cnt_q == 5'(i)) begin
                            mat_a_d[143-16*i -: 16] = in_data;
                        end
                        if (cnt_q == 5'(i + 9)) begin
                            mat_b_d[143-16*i -: 16] = in_data;
                        end
                    end
                    if (cnt_q == 5'd17) begin
                        cnt_d   = 5'd0;
                        state_d = ST_CAPTURE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_CAPTURE: begin
                res_d   = Result;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (emit) begin
                    if (idx_q == 4'd8) begin
                        idx_d   = 4'd0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = 5'd0;
                idx_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= 5'd0;
            idx_q   <= 4'd0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            res_q   <= res_d;
        end
    end

    // Handshake outputs are forced low for the whole reset pulse.
    always_comb begin
        in_ready  = !rst && (state_q == ST_LOAD);
        out_valid = !rst && (state_q == ST_SEND);
        out_last  = !rst && (state_q == ST_SEND) && (idx_q == 4'd8);
        out_data  = (!rst && (state_q == ST_SEND)) ? res_elem : 16'h0000;
        busy      = !rst && ((state_q != ST_LOAD) || (cnt_q != 5'd0));
    end

    assign matrix_A = mat_a_q;
    assign matrix_B = mat_b_q;

endmodule

// File: tb/tb_matrix_stream_io.sv
// Directed and randomized checks of matrix_stream_io against an
// arithmetic reference of the 3x3 product streamed row-major.
module tb_matrix_stream_io;

    typedef logic [15:0] mat_t [9];

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [143:0] matrix_A;
    logic [143:0] matrix_B;
    logic [143:0] Result;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    matrix_stream_io dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .matrix_A  (matrix_A),
        .matrix_B  (matrix_B),
        .Result    (Result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External combinational multiplier, wrapping modulo 2^16.
    function automatic logic [143:0] mult_flat(input logic [143:0] a,
                                               input logic [143:0] b);
        logic [143:0] r;
        logic [15:0]  s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 16'h0;
                for (int k = 0; k < 3; k++) begin
                    s = s + a[143-16*(3*i+k) -: 16] * b[143-16*(3*k+j) -: 16];
                end
                r[143-16*(3*i+j) -: 16] = s;
            end
        end
        return r;
    endfunction

    assign Result = mult_flat(matrix_A, matrix_B);

    function automatic logic [143:0] pack(input mat_t m);
        logic [143:0] r;
        for (int i = 0; i < 9; i++) r[143-16*i -: 16] = m[i];
        return r;
    endfunction

    task automatic ref_product(input mat_t a, input mat_t b, output mat_t p);
        longint acc;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = 0;
                for (int k = 0; k < 3; k++) begin
                    acc += longint'(a[3*i+k]) * longint'(b[3*k+j]);
                end
                p[3*i+j] = 16'(acc % 65536);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [143:0] obs,
                       input logic [143:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pair(input mat_t a, input mat_t b,
                             input int max_gap, input bit keep_valid);
        int gaps;
        for (int s = 0; s < 18; s++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                @(negedge clk);
                chk("ld_gap_rdy", in_ready, 1);
                tick();
            end
            in_valid = 1'b1;
            in_data  = (s < 9) ? a[s] : b[s-9];
            @(negedge clk);
            chk("ld_rdy", in_ready, 1);
            chk("ld_oval", out_valid, 0);
            tick();
        end
        in_valid = keep_valid;
        in_data  = 16'($urandom);
        @(negedge clk);
        chk("cap_oval", out_valid, 0);
        chk("cap_rdy", in_ready, 0);
        chk("cap_busy", busy, 1);
        chk("mat_a", matrix_A, pack(a));
        chk("mat_b", matrix_B, pack(b));
        tick();
    endtask

    task automatic recv(input mat_t exp, input int stall_idx,
                        input int stall_len, input bit rand_ready,
                        input bit valid_in_send);
        int k = 0;
        int stalled = 0;
        int cyc = 0;
        while (k < 9 && cyc < 300) begin
            if (k == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            in_valid = valid_in_send;
            in_data  = 16'($urandom);
            @(negedge clk);
            chk("snd_oval", out_valid, 1);
            chk("snd_rdy", in_ready, 0);
            chk("snd_data", out_data, exp[k]);
            chk("snd_last", out_last, (k == 8));
            if (out_ready && out_valid) k++;
            cyc++;
            tick();
        end
        chk("snd_count", k, 9);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("post_rdy", in_ready, 1);
        chk("post_oval", out_valid, 0);
        chk("post_busy", busy, 0);
        tick();
    endtask

    task automatic pair(input mat_t a, input mat_t b, input int max_gap,
                        input bit keep_valid, input int stall_idx,
                        input int stall_len, input bit rand_ready);
        mat_t p;
        ref_product(a, b, p);
        load_pair(a, b, max_gap, keep_valid);
        recv(p, stall_idx, stall_len, rand_ready, keep_valid);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t ident, seq, two_i, ones, ra, rb, p;
        ident = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
        seq   = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        two_i = '{16'd2, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd0, 16'd2};
        for (int i = 0; i < 9; i++) ones[i] = 16'hFFFF;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_rdy", in_ready, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mat_a", matrix_A, 0);
        chk("rst_mat_b", matrix_B, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rdy", in_ready, 1);
        chk("rel_busy", busy, 0);
        tick();

        // Identity with uninterrupted streaming
        pair(ident, seq, 0, 1'b0, -1, 0, 1'b0);
        // All-ones wrap: every element 3
        ref_product(ones, ones, p);
        chk("ovf_model", p[4], 16'h0003);
        pair(ones, ones, 0, 1'b0, -1, 0, 1'b0);
        // Backpressure at idx 3 for 5 cycles
        pair(ident, seq, 0, 1'b0, 3, 5, 1'b0);
        // Input gaps and in_valid held high through SEND
        pair(ident, seq, 1, 1'b1, -1, 0, 1'b0);

        // Reset after 7 accepted elements
        for (int s = 0; s < 7; s++) begin
            in_valid = 1'b1;
            in_data  = ones[s];
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("part_busy", busy, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", in_ready, 0);
        chk("mrst_busy", busy, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_rel_busy", busy, 0);
        tick();
        pair(ident, seq, 0, 1'b0, -1, 0, 1'b0);

        // Reset during SEND
        load_pair(ident, seq, 0, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rsnd_data", out_data, seq[k]);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rsnd_oval_rst", out_valid, 0);
        chk("rsnd_data_rst", out_data, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rsnd_oval_after", out_valid, 0);
            chk("rsnd_rdy_after", in_ready, 1);
            tick();
        end
        out_ready = 1'b0;

        // Back-to-back identity then 2I
        pair(ident, seq, 0, 1'b0, -1, 0, 1'b0);
        pair(two_i, seq, 0, 1'b0, -1, 0, 1'b0);

        // Randomized pairs
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 9; i++) begin
                ra[i] = 16'($urandom);
                rb[i] = 16'($urandom);
            end
            pair(ra, rb, 2, 1'($urandom_range(0, 1)), -1, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_stream_io.md
MATRIX_STREAM_IO -- requirements
Module: matrix_stream_io

Interface
REQ-001 The block SHALL have no parameters; element width SHALL be fixed at 16 bits and matrix size fixed at 3x3.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  16  serial matrix element.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 matrix_A  output  144  packed operand A to the multiplier; [0][0] in bits 143:128, row-major, [2][2] in bits 15:0.
REQ-008 matrix_B  output  144  packed operand B to the multiplier; same packing as matrix_A.
REQ-009 Result  input  144  packed product from the combinational multiplier; same packing.
REQ-010 out_data  output  16  serial result element.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_last  output  1  marks the 9th (final) result element.
REQ-014 busy  output  1  a matrix pair is partly loaded, being captured, or being sent.

Function
REQ-015 States SHALL be LOAD, CAPTURE and SEND; reset state SHALL be LOAD.
REQ-016 LOAD: in_ready=1; a transfer SHALL occur when in_valid&in_ready, writing in_data to slot cnt (0..17) and incrementing cnt.
REQ-017 Slots 0-8 SHALL fill matrix_A row-major ([0][0],[0][1],...,[2][2]); slots 9-17 SHALL fill matrix_B row-major.
REQ-018 Accepting slot 17 SHALL move LOAD->CAPTURE on the next edge; cnt SHALL clear to 0.
REQ-019 in_valid low SHALL stall LOAD indefinitely with no state change; gaps between elements SHALL be allowed.
REQ-020 in_ready SHALL be 0 in CAPTURE and SEND; in_valid SHALL be ignored there.
REQ-021 matrix_A/matrix_B SHALL be registers, held stable from the load of their last slot until that slot is overwritten by the next load.
REQ-022 CAPTURE SHALL last exactly one cycle: Result SHALL be registered into a 144-bit result buffer, then CAPTURE->SEND.
REQ-023 SEND: out_valid=1; out_data SHALL be result element idx (0..8), row-major, idx 0 = Result[143:128].
REQ-024 idx SHALL advance only on out_valid&out_ready; out_data, out_last and out_valid SHALL hold while out_ready=0.
REQ-025 out_last SHALL be 1 only while idx=8 in SEND.
REQ-026 Handshake on idx=8 SHALL move SEND->LOAD, clear idx, and set in_ready=1 on the following cycle.
REQ-027 Latency: 18th input accepted at edge T -> CAPTURE during cycle T+1 -> first out_valid during cycle T+2.
REQ-028 Arithmetic SHALL be the multiplier's; the block SHALL pass 16-bit elements unmodified (products and sums wrap modulo 2^16 upstream).
REQ-029 busy SHALL be 1 when state!=LOAD or cnt!=0, else 0.
REQ-030 Minimum throughput: 18 input cycles + 1 capture + 9 output cycles per matrix pair, with no extra idle cycles.

Reset
REQ-031 While rst=1 at an edge: state=LOAD, cnt=0, idx=0, matrix_A=0, matrix_B=0, result buffer=0.
REQ-032 Outputs SHALL be 0 while rst=1: out_valid, out_last, out_data, busy and in_ready; in_ready SHALL be 1 in the first cycle after rst falls.
REQ-033 Reset mid-LOAD or mid-SEND SHALL discard all partial input and pending output; no element SHALL be emitted afterwards until a complete new 18-element load.

Verification
REQ-034 Identity: A=I (1,0,0,0,1,0,0,0,1), B=1..9, out_ready=1 -> out_data 1,2,...,9 on 9 consecutive cycles starting 2 cycles after the 18th accept; out_last only on 9.
REQ-035 Overflow: all 18 inputs 0xFFFF -> 9 outputs each 0x0003.
REQ-036 Backpressure: identity case with out_ready=0 for 5 cycles at idx=3 -> out_data holds 4 for those cycles; the full sequence 1..9 is received with none lost or duplicated.
REQ-037 Input gaps: in_valid toggled 1/0 during load, plus in_valid=1 asserted during SEND -> same outputs as REQ-034; no extra accepts; in_ready=0 throughout SEND.
REQ-038 Reset mid-operation: rst for 1 cycle after 7 elements, then a full identity load -> outputs 1..9 only. rst during SEND -> out_valid=0 from the next cycle.
REQ-039 Back-to-back: identity pair followed by A=2I, B=1..9 -> 1..9, then 2,4,...,18; in_ready returns 1 exactly one cycle after the first out_last handshake.
